// File: rtl/mem_stream_reader.sv
// Streams a contiguous run of words out of a one-cycle-latency RAM over valid/ready.
// A 2-entry output buffer plus credit-limited read issue absorbs downstream stalls.
module mem_stream_reader #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   issue_cnt_q, issue_cnt_d;
    logic [AW:0]   acc_cnt_q, acc_cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    wr_idx;
    logic          pop, push;

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_FIN);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf0_q;

    always_comb begin
        pop  = out_valid && out_ready;
        push = inflight_q;
        // Only issue if the word can still land in the buffer after this cycle's pop.
        rd_en = (state_q == S_RUN) && (issue_cnt_q != '0) &&
                ((3'(cnt_q) + 3'(inflight_q) - 3'(pop)) <= 3'd1);
        rd_addr = rd_en ? ptr_q : last_addr_q;
    end

    always_comb begin
        cnt_d  = cnt_q + 2'(push) - 2'(pop);
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        wr_idx = cnt_q - 2'(pop);
        if (pop) buf0_d = buf1_q;
        // Push goes behind whatever survives the pop, so order is preserved.
        if (push) begin
            if (wr_idx == 2'd0) buf0_d = rd_data;
            else                buf1_d = rd_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        ptr_d       = ptr_q;
        last_addr_d = last_addr_q;
        inflight_d  = rd_en;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d       = base_addr;
                    issue_cnt_d = len;
                    acc_cnt_d   = len;
                    state_d     = (len == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en) begin
                    issue_cnt_d = issue_cnt_q - (AW+1)'(1);
                    ptr_d       = ptr_q + AW'(1);
                    last_addr_d = ptr_q;
                end
                if (pop) begin
                    acc_cnt_d = acc_cnt_q - (AW+1)'(1);
                    if (acc_cnt_q == (AW+1)'(1)) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            ptr_q       <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            ptr_q       <= ptr_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
